multicycle_sequencer: RTL
=========================

// Module: multicycle_sequencer
// PURPOSE
// Multi-cycle FSM that sequences the processor datapath: fetch, decode, execute, memory, writeback.
// Holds the PC and latches the instruction register (ir). Consumes the decoded control bits
// (regRW, MRW, WB, PCsrc) produced from ir, and issues one-cycle register-write strobes.
// Issues ready-handshaked requests to instruction and data memory, counts retired instructions,
// and traps to a sticky fault state on a memory timeout.
// PARAMETERS
// PC_WIDTH     32   width of pc and pc_target
// RESET_PC     0    pc value after reset
// MEM_TIMEOUT  15   max consecutive req-without-ready cycles before FAULT; 0 disables timeout
// PORTS
// clk         in   1         rising-edge clock
// rst_n       in   1         asynchronous, active-low reset
// run         in   1         1 = fetch/execute instructions; sampled only at IDLE and at retire
// imem_req    out  1         instruction fetch request, held until imem_ready
// imem_ready  in   1         instruction memory data valid this cycle
// imem_rdata  in   32        fetched instruction
// ir          out  32        latched instruction, fed to control decode
// regRW       in   1         decoded: instruction writes register file
// MRW         in   1         decoded: store (memory write)
// WB          in   1         decoded: load (writeback from memory)
// PCsrc       in   1         decoded: unconditional jump/return
// br_taken    in   1         branch condition true (valid in EXEC)
// pc_target   in   PC_WIDTH  jump/branch target (valid in EXEC)
// pc          out  PC_WIDTH  current program counter
// reg_we      out  1         register-file write strobe, one cycle
// dmem_req    out  1         data memory request, held until dmem_ready
// dmem_we     out  1         1 = store, 0 = load; valid while dmem_req=1
// dmem_ready  in   1         data memory access complete this cycle
// state       out  3         IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 FAULT=6
// retired     out  16        retired-instruction count, wraps 16'hFFFF -> 0
// fault       out  1         sticky; 1 while state==FAULT
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=0, retired=0, wait counter=0; all strobes/reqs/fault 0.
//   Reset asserted mid-operation aborts immediately; no partial PC/counter update.
// - IDLE: run=1 -> FETCH; else stay.
// - FETCH: imem_req=1. On imem_ready: ir<=imem_rdata, -> DECODE.
// - DECODE: exactly 1 cycle, no outputs asserted -> EXEC.
// - EXEC: 1 cycle. MRW or WB -> MEM (MRW has priority); else regRW -> WB; else retire.
// - MEM: dmem_req=1, dmem_we=MRW. On dmem_ready: WB=1 and MRW=0 -> WB; else retire.
// - WB: reg_we=1 for this single cycle, then retire.
// - Retire (last cycle of instruction): pc <= (PCsrc|br_taken) ? pc_target : pc+4 (mod 2^PC_WIDTH).
//   Same cycle retired++; next state FETCH if run=1, else IDLE.
//   br_taken/pc_target are captured in EXEC and used at retire.
// - run=0 never aborts an in-flight instruction.
// - Timeout: wait counter clears on entry to FETCH/MEM. It increments each cycle req=1 and ready=0.
//   If it reaches MEM_TIMEOUT with ready still 0 -> FAULT. Ready in that same cycle wins (no fault).
// - FAULT: all reqs/strobes 0, pc/ir/retired frozen, fault=1. Exit only by reset.
// - reg_we, dmem_req, imem_req are never asserted simultaneously.
// - Latency with zero-wait memory: ALU op 4 cycles, load 5, store 4, jump/branch 3.
// TESTING
// 1 rst_n=0 mid-MEM -> same cycle state=0, pc=RESET_PC, dmem_req=0, retired=0.
// 2 run=1, imem_rdata=32'h00450693, regRW=1, imem_ready 1st cycle ->
//   FETCH,DECODE,EXEC,WB; one reg_we pulse; pc=4; retired=1.
// 3 load 32'h0006a803 (regRW=WB=1), dmem_ready after 3 wait cycles ->
//   dmem_req high 4 cycles with dmem_we=0; then reg_we pulse; pc+=4.
// 4 jump 32'hfc1ff06f (PCsrc=1), pc_target=32'h40 -> no reg_we, no dmem_req; pc=32'h40 after EXEC.
// 5 imem_ready held 0 -> after 15 wait cycles state=6, fault=1.
//   Toggling run changes nothing; only rst_n clears it.
// 6 store 32'h01162023 with run dropped during MEM -> store completes (dmem_we=1), retired++, state=IDLE.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with memory timeout trap
module multicycle_sequencer #(
    parameter int                  PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic                imem_req,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         ir,
    input  logic                regRW,
    input  logic                MRW,
    input  logic                WB,
    input  logic                PCsrc,
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] pc_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                reg_we,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ready,
    output logic [2:0]          state,
    output logic [15:0]         retired,
    output logic                fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t              st, nxt;
    logic [CW-1:0]       wait_cnt;
    logic                take_q;
    logic [PC_WIDTH-1:0] tgt_q;
    logic                retire, mem_req_now, mem_ready, timeout, take;
    logic [PC_WIDTH-1:0] tgt, pc_next;

    always_comb begin
        mem_req_now = (st == S_FETCH) || (st == S_MEM);
        mem_ready   = (st == S_FETCH) ? imem_ready : dmem_ready;
        timeout     = (MEM_TIMEOUT != 0) && mem_req_now && !mem_ready &&
                      (int'(wait_cnt) + 1 >= MEM_TIMEOUT);

        // A jump retires in EXEC itself, so it uses the live branch inputs there.
        take    = (st == S_EXEC) ? (PCsrc | br_taken) : take_q;
        tgt     = (st == S_EXEC) ? pc_target : tgt_q;
        pc_next = take ? tgt : pc + PC_WIDTH'(4);

        retire = 1'b0;
        nxt    = st;
        case (st)
            S_IDLE:   nxt = run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                if (imem_ready)   nxt = S_DECODE;
                else if (timeout) nxt = S_FAULT;
            end
            S_DECODE: nxt = S_EXEC;
            S_EXEC: begin
                if (MRW || WB) nxt = S_MEM;
                else if (regRW) nxt = S_WB;
                else retire = 1'b1;
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (WB && !MRW) nxt = S_WB;
                    else retire = 1'b1;
                end else if (timeout) begin
                    nxt = S_FAULT;
                end
            end
            S_WB:     retire = 1'b1;
            S_FAULT:  nxt = S_FAULT;
            default:  nxt = S_FAULT;
        endcase
        if (retire) nxt = run ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            retired  <= '0;
            wait_cnt <= '0;
            take_q   <= 1'b0;
            tgt_q    <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            reg_we   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            st       <= nxt;
            imem_req <= (nxt == S_FETCH);
            dmem_req <= (nxt == S_MEM);
            dmem_we  <= (nxt == S_MEM) && MRW;
            reg_we   <= (nxt == S_WB);
            fault    <= (nxt == S_FAULT);

            if (st == S_FETCH && imem_ready) ir <= imem_rdata;
            if (st == S_EXEC) begin
                take_q <= PCsrc | br_taken;
                tgt_q  <= pc_target;
            end
            if (retire) begin
                pc      <= pc_next;
                retired <= retired + 16'd1;
            end

            // Any state change restarts the wait budget; only stalled requests count.
            if (nxt != st)                      wait_cnt <= '0;
            else if (mem_req_now && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign state = st;

endmodule
